// File: rtl/cronometro_voltas.sv
// Stopwatch with tenths/seconds counting, keypad command decoding and an optional lap buffer.
// Define CRON_VOLTAS_EN to build the lap buffer with B-capture and C-recall.
module cronometro_voltas #(
  parameter int CLK_HZ    = 1000,
  parameter int SEG_W     = 10,
  parameter int SEG_MAX   = 999,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ativo,
  input  logic [4:0]       key,
  output logic [3:0]       decs,
  output logic [SEG_W-1:0] segs,
  output logic             rodando,
  output logic             vendo_volta,
  output logic [3:0]       volta_idx,
  output logic [4:0]       n_voltas,
  output logic             voltas_cheio,
  output logic             estouro
);

  localparam int DIV   = CLK_HZ / 10;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [4:0] T_NULL = 5'd31;
  localparam logic [4:0] K_A    = 5'd10;
  localparam logic [4:0] K_B    = 5'd11;

  typedef enum logic {PARADO, RODANDO} estado_t;

  estado_t          est_q, est_d;
  logic [4:0]       tecla_q, tecla_ant_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       decs_q, decs_d;
  logic [SEG_W-1:0] segs_q, segs_d;
  logic             estouro_q, estouro_d;
  logic             evento, tick, cmd_a, cmd_b;

  // A press is the first cycle a registered key differs from T_NULL
  assign evento = ativo && (tecla_q != T_NULL) && (tecla_ant_q == T_NULL);
  assign cmd_a  = evento && (tecla_q == K_A);
  assign cmd_b  = evento && (tecla_q == K_B);
  assign tick   = (est_q == RODANDO) && (pre_q == PRE_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      est_q       <= PARADO;
      tecla_q     <= T_NULL;
      tecla_ant_q <= T_NULL;
      pre_q       <= '0;
      decs_q      <= '0;
      segs_q      <= '0;
      estouro_q   <= 1'b0;
    end else begin
      est_q       <= est_d;
      tecla_q     <= key;
      tecla_ant_q <= tecla_q;
      pre_q       <= pre_d;
      decs_q      <= decs_d;
      segs_q      <= segs_d;
      estouro_q   <= estouro_d;
    end
  end

  always_comb begin
    est_d     = est_q;
    pre_d     = pre_q;
    decs_d    = decs_q;
    segs_d    = segs_q;
    estouro_d = estouro_q;

    if (est_q == RODANDO) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end

    if (tick) begin
      if (decs_q == 4'd9) begin
        decs_d = '0;
        if (segs_q == SEG_W'(SEG_MAX)) begin
          segs_d    = '0;
          estouro_d = 1'b1;
        end else begin
          segs_d = segs_q + 1'b1;
        end
      end else begin
        decs_d = decs_q + 4'd1;
      end
    end

    // A stop lets a coincident tick land first; a start restarts the tenth from zero
    if (cmd_a) begin
      if (est_q == PARADO) begin
        est_d = RODANDO;
        pre_d = '0;
      end else begin
        est_d = PARADO;
      end
    end

    if (cmd_b && (est_q == PARADO)) begin
      pre_d     = '0;
      decs_d    = '0;
      segs_d    = '0;
      estouro_d = 1'b0;
    end
  end

  assign rodando = (est_q == RODANDO);
  assign estouro = estouro_q;

`ifdef CRON_VOLTAS_EN
  localparam int IDX_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [4:0] K_C = 5'd12;

  logic [SEG_W+3:0] buf_q [LAP_DEPTH];
  logic [4:0]       n_q, n_d;
  logic [3:0]       idx_q, idx_d;
  logic             vendo_q, vendo_d;
  logic             cheio, limpa, captura, recall;

  assign cheio   = (n_q == 5'(LAP_DEPTH));
  assign limpa   = cmd_b && (est_q == PARADO);
  assign captura = cmd_b && (est_q == RODANDO) && !cheio;
  assign recall  = evento && (tecla_q == K_C) && (n_q != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q     <= '0;
      idx_q   <= '0;
      vendo_q <= 1'b0;
    end else begin
      n_q     <= n_d;
      idx_q   <= idx_d;
      vendo_q <= vendo_d;
    end
  end

  // Stores the pre-tick live value; contents are hidden by n_q after reset
  always_ff @(posedge clk) begin
    if (!rst && captura) begin
      buf_q[n_q[IDX_W-1:0]] <= {segs_q, decs_q};
    end
  end

  always_comb begin
    n_d     = n_q;
    idx_d   = idx_q;
    vendo_d = vendo_q;
    if (limpa) begin
      n_d     = '0;
      idx_d   = '0;
      vendo_d = 1'b0;
    end else if (captura) begin
      n_d = n_q + 5'd1;
    end else if (recall) begin
      if (!vendo_q) begin
        vendo_d = 1'b1;
        idx_d   = '0;
      end else if ({1'b0, idx_q} == n_q - 5'd1) begin
        vendo_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  assign {segs, decs}  = vendo_q ? buf_q[idx_q[IDX_W-1:0]] : {segs_q, decs_q};
  assign vendo_volta   = vendo_q;
  assign volta_idx     = idx_q;
  assign n_voltas      = n_q;
  assign voltas_cheio  = cheio;
`else
  assign decs         = decs_q;
  assign segs         = segs_q;
  assign vendo_volta  = 1'b0;
  assign volta_idx    = '0;
  assign n_voltas     = '0;
  // Always 0 since LAP_DEPTH is at least 2; keeps the depth parameter referenced
  assign voltas_cheio = (LAP_DEPTH == 0);
`endif

endmodule

// File: doc/cronometro_voltas.md
# cronometro_voltas

Parametrised stopwatch with lap memory, successor to the fixed-rate tenths/seconds counter under the stopwatch/calculator top. It counts tenths and seconds from a `CLK_HZ` clock and decodes its own keypad commands: start/stop, lap capture, clear and lap recall. A `LAP_DEPTH`-entry lap buffer can be browsed while the count continues. The parent top keeps mode switching and drives `ativo`.

## Interface
- `CLK_HZ`, 1000: input clock frequency; must be a multiple of 10, at least 10.
- `SEG_W`, 10: width of the seconds counter.
- `SEG_MAX`, 999: last seconds value before wrap; must be below 2^SEG_W.
- `LAP_DEPTH`, 4: lap buffer entries, 2..16.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ativo`  in  1  keys are decoded only while high.
- `key`  in  5  keypad code: 0-9 digits, 10=A, 11=B, 12=C, 13=D, 14=*, 15=#, 31=T_NULL (no key).
- `decs`  out  4  displayed tenths, 0..9.
- `segs`  out  SEG_W  displayed seconds.
- `rodando`  out  1  counter running.
- `vendo_volta`  out  1  display shows a stored lap, not the live count.
- `volta_idx`  out  4  index of the lap shown; 0 when not viewing.
- `n_voltas`  out  5  laps stored, 0..LAP_DEPTH.
- `voltas_cheio`  out  1  `n_voltas == LAP_DEPTH`.
- `estouro`  out  1  sticky flag: the count has wrapped.

## Operation
- **Key capture.** `key` is registered every cycle into `tecla`, and the previous `tecla` is kept.
  - A press event is `tecla != 31` while the previous `tecla == 31`.
  - Held keys produce one event only.
  - Events are discarded while `ativo == 0`.
- **Commands.** Only A, B and C act. Digits, D, * and # are ignored.
- **A: start/stop.**
  - Stopped to running: the prescaler clears to 0.
  - Running to stopped: the prescaler holds.
- **B while running: lap capture.**
  - Writes live `{segs,decs}` to entry `n_voltas`, then increments `n_voltas`.
  - Ignored when `voltas_cheio`.
- **B while stopped: clear.**
  - Live count goes to 0.0, the prescaler to 0, `n_voltas` to 0 and `estouro` to 0.
  - Leaves view mode.
- **C: recall.**
  - Ignored when `n_voltas == 0`.
  - From live view it enters view mode at index 0.
  - In view mode it advances the index. After index `n_voltas-1` it returns to live view.
- **Display mux.**
  - In view mode, `decs`/`segs` show buffer entry `volta_idx`.
  - Otherwise they show the live count.
  - The live count continues in either case.
- **Counting while inactive.** Counting runs regardless of `ativo`, so the stopwatch keeps timing in background.
- **Prescaler.**
  - While running it counts 0..CLK_HZ/10-1.
  - At the terminal value it emits a tick and returns to 0.
- **Tick.**
  - `decs` increments. At 9 it goes to 0 and `segs` increments.
  - At `segs == SEG_MAX` and `decs == 9`, the count wraps to 0.0, `estouro` sets, and counting continues.
- **Simultaneous tick and capture.** A tick and a capture in the same cycle store the pre-tick value.
- **Reset.** Reset in any state clears everything. Buffer contents need not clear, since `n_voltas = 0` hides them.

## Timing
- **Reset values:** `decs` 0, `segs` 0, `rodando` 0, `vendo_volta` 0, `volta_idx` 0, `n_voltas` 0, `voltas_cheio` 0, `estouro` 0. All outputs are registered or driven by a registered mux.
- **Key latency:** code on `key` at edge n, `tecla` updates at n+1, and the command's effect is visible after edge n+2.
- **First tick after start:** after CLK_HZ/10 running cycles. At 1000 Hz, 0.1 appears 100 cycles after `rodando` rises.
- **Priority when `rst` and an event coincide:** `rst` wins.
- **Stop/start latency:** a stop pressed in the cycle a tick would fire takes effect after the tick.

## Configuration
- **`CRON_VOLTAS_EN` defined:** lap buffer and C/B-capture logic are present, as described above.
- **`CRON_VOLTAS_EN` undefined:**
  - No buffer is instantiated.
  - B while running and C are ignored.
  - `vendo_volta`, `volta_idx`, `n_voltas` and `voltas_cheio` are tied to 0.
  - B while stopped still clears the count and `estouro`.

## Test plan
- **Start:** reset, `ativo` 1, press A, run 1000 cycles -> `decs` 0, `segs` 1, `rodando` 1. Press A again -> the count freezes.
- **Held key:** hold A for 50 cycles -> exactly one toggle. Press A with `ativo` 0 -> no change.
- **Capture, full buffer:** run, then press B at 1.2, 2.5, 3.1, 4.0 and 5.0 -> `n_voltas` 4, `voltas_cheio` 1, and the fifth press is ignored.
- **Recall:**
  - With 4 laps, press C four times -> shows 1.2, 2.5, 3.1, 4.0 with `volta_idx` 0..3.
  - A fifth C -> `vendo_volta` 0 and the live count, which kept advancing.
- **Wrap:** `SEG_MAX` 2, run 30 tenths -> 0.0 with `estouro` 1. Stop, press B -> `estouro` 0 and `n_voltas` 0.
- **Mid-count reset:** assert `rst` at 3.7 while viewing -> all outputs return to their reset values on the next edge. With `CRON_VOLTAS_EN` undefined, B while running -> no effect.
